pingpong_block_buffer: RTL and testbench

- Parametrised successor of the 64x8 pixel block buffer: two banks of BLOCK_DIM x BLOCK_DIM samples, used as a ping-pong buffer.
- One bank is filled by a raster-order valid/ready input stream while the other bank drains as a valid/ready output stream.
- The output order is selectable: raster, transposed (column-major, between DCT passes) or JPEG zigzag (ahead of the quantiser/entropy coder).

---
 rtl/pingpong_block_buffer.sv | 171 +++++++++++++++++
 tb/tb_pingpong_block_buffer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_block_buffer.sv
// Two-bank N x N sample buffer: one bank fills from a raster-order stream while
// the other drains in raster, transposed or JPEG zigzag order.
module pingpong_block_buffer #(
    parameter  int DATA_WIDTH = 8,
    parameter  int BLOCK_DIM  = 8,
    localparam int DEPTH      = BLOCK_DIM * BLOCK_DIM,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            rd_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [ADDR_W-1:0]     out_index,
    output logic [1:0]            bank_full
);
    localparam int RC_W  = $clog2(BLOCK_DIM);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(BLOCK_DIM - 1);
    localparam logic [ADDR_W-1:0] DIM_A    = ADDR_W'(BLOCK_DIM);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_END  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {BANK_EMPTY, BANK_FULL, BANK_DRAINING} bank_state_t;
    typedef enum logic [1:0] {MODE_RASTER, MODE_TRANSPOSE, MODE_ZIGZAG} read_mode_t;
    typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_t;

    logic [DATA_WIDTH-1:0] mem [2][DEPTH];
    bank_state_t           bank_st [2];
    logic                  wr_bank, rd_bank;
    logic [ADDR_W-1:0]     wr_idx;
    rd_state_t             rd_state, rd_state_next;
    read_mode_t            mode_q;
    logic [RC_W-1:0]       pos_r, pos_c, next_r, next_c;
    logic [CNT_W-1:0]      rd_cnt;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  wr_open, wr_fire, start_drain, load, last_fire;

    // Write acceptance depends only on registered bank state, never on out_ready.
    assign wr_open   = (bank_st[wr_bank] == BANK_EMPTY);
    assign in_ready  = reset_n && wr_open;
    assign wr_fire   = in_valid && wr_open;
    assign bank_full = {bank_st[1] != BANK_EMPTY, bank_st[0] != BANK_EMPTY};

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        rd_state_next = rd_state;
        start_drain   = 1'b0;
        load          = 1'b0;
        last_fire     = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (bank_st[rd_bank] == BANK_FULL) begin
                    start_drain   = 1'b1;
                    rd_state_next = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                load      = (!out_valid || out_ready) && (rd_cnt != CNT_END);
                last_fire = out_valid && out_ready && out_last;
                if (last_fire) rd_state_next = RD_IDLE;
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_addr = (mode_q == MODE_TRANSPOSE) ? ADDR_W'(pos_c) * DIM_A + ADDR_W'(pos_r)
                                             : ADDR_W'(pos_r) * DIM_A + ADDR_W'(pos_c);
        next_r = pos_r;
        next_c = pos_c;
        if (mode_q == MODE_ZIGZAG) begin
            // Even anti-diagonals climb up-right, odd ones descend down-left.
            if ((pos_r[0] ^ pos_c[0]) == 1'b0) begin
                if (pos_c == RC_LAST) begin
                    next_r = pos_r + 1'b1;
                end else if (pos_r == '0) begin
                    next_c = pos_c + 1'b1;
                end else begin
                    next_r = pos_r - 1'b1;
                    next_c = pos_c + 1'b1;
                end
            end else begin
                if (pos_r == RC_LAST) begin
                    next_c = pos_c + 1'b1;
                end else if (pos_c == '0) begin
                    next_r = pos_r + 1'b1;
                end else begin
                    next_r = pos_r + 1'b1;
                    next_c = pos_c - 1'b1;
                end
            end
        end else if (pos_c == RC_LAST) begin
            next_r = pos_r + 1'b1;
            next_c = '0;
        end else begin
            next_c = pos_c + 1'b1;
        end
    end

    // NOTE: sample storage is not reset; only the control state says what is valid.
    always_ff @(posedge clock) begin
        if (wr_fire) mem[wr_bank][wr_idx] <= in_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rd_state <= RD_IDLE;
        else          rd_state <= rd_state_next;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bank_st[0] <= BANK_EMPTY;
            bank_st[1] <= BANK_EMPTY;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_idx     <= '0;
            mode_q     <= MODE_RASTER;
            pos_r      <= '0;
            pos_c      <= '0;
            rd_cnt     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_index  <= '0;
        end else begin
            if (wr_fire) begin
                if (wr_idx == IDX_LAST) begin
                    wr_idx           <= '0;
                    bank_st[wr_bank] <= BANK_FULL;
                    wr_bank          <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
            if (start_drain) begin
                case (rd_mode)
                    2'd1:    mode_q <= MODE_TRANSPOSE;
                    2'd2:    mode_q <= MODE_ZIGZAG;
                    default: mode_q <= MODE_RASTER;
                endcase
                pos_r            <= '0;
                pos_c            <= '0;
                rd_cnt           <= '0;
                bank_st[rd_bank] <= BANK_DRAINING;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= mem[rd_bank][rd_addr];
                out_index <= rd_addr;
                out_last  <= (rd_cnt == CNT_END - 1'b1);
                rd_cnt    <= rd_cnt + 1'b1;
                pos_r     <= next_r;
                pos_c     <= next_c;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (last_fire) begin
                bank_st[rd_bank] <= BANK_EMPTY;
                rd_bank          <= ~rd_bank;
            end
        end
    end
endmodule

// File: tb/tb_pingpong_block_buffer.sv
// Bench for pingpong_block_buffer: directed vector table, backpressure, random
// stalls with mid-block mode changes, and mid-stream resets, all scoreboarded.
module tb_pingpong_block_buffer;
    localparam int DW    = 8;
    localparam int N     = 8;
    localparam int DEPTH = N * N;
    localparam int AW    = 6;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    rd_mode;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [AW-1:0] out_index;
    logic [1:0]    bank_full;

    pingpong_block_buffer #(.DATA_WIDTH(DW), .BLOCK_DIM(N)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .rd_mode(rd_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .out_index(out_index), .bank_full(bank_full)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] idx;
        logic          last;
    } exp_t;

    typedef struct {
        logic [1:0]    mode;
        int            pos;
        logic [DW-1:0] data;
        logic          last;
    } vec_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    exp_t          exp_q[$];
    vec_t          vecs[$];
    logic [DW-1:0] part[DEPTH];
    int            part_n;
    int            order_tab[4][DEPTH];
    logic [1:0]    blk_mode[16];
    int            blk_in, blk_out;
    bit            stall_prev;
    logic [DW+AW:0] held;
    bit            in_acc;
    int            first_valid_cyc, first_ready_cyc, first_last_cyc, last_in_cyc;
    int            n_out, n_valid_seen, cap_n;
    logic [DW-1:0] cap_data[DEPTH];
    logic [AW-1:0] cap_idx[DEPTH];
    logic          cap_last[DEPTH];
    logic [DW-1:0] mode_data[3][DEPTH];
    logic [AW-1:0] mode_idx[3][DEPTH];
    logic          mode_last[3][DEPTH];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Output orders from the block geometry: zigzag walks anti-diagonals,
    // odd diagonals top-to-bottom, even ones bottom-to-top.
    task automatic init_orders();
        int k;
        for (int i = 0; i < DEPTH; i++) begin
            order_tab[0][i] = i;
            order_tab[3][i] = i;
            order_tab[1][i] = (i % N) * N + (i / N);
        end
        k = 0;
        for (int d = 0; d <= 2 * N - 2; d++) begin
            int lo, hi;
            lo = (d < N) ? 0 : d - N + 1;
            hi = (d < N) ? d : N - 1;
            if (d % 2 == 1) begin
                for (int r = lo; r <= hi; r++) begin
                    order_tab[2][k] = r * N + (d - r);
                    k++;
                end
            end else begin
                for (int r = hi; r >= lo; r--) begin
                    order_tab[2][k] = r * N + (d - r);
                    k++;
                end
            end
        end
    endtask

    task automatic start_phase();
        exp_q.delete();
        part_n = 0; blk_in = 0; blk_out = 0; stall_prev = 1'b0;
        first_valid_cyc = -1; first_ready_cyc = -1; first_last_cyc = -1; last_in_cyc = -1;
        n_out = 0; n_valid_seen = 0; cap_n = 0;
    endtask

    task automatic model_accept(input logic [DW-1:0] d);
        int m, a;
        part[part_n] = d;
        part_n++;
        if (part_n == DEPTH) begin
            m = int'(blk_mode[blk_in % 16]);
            for (int i = 0; i < DEPTH; i++) begin
                a = order_tab[m][i];
                exp_q.push_back('{data: part[a], idx: AW'(a), last: (i == DEPTH - 1)});
            end
            part_n = 0;
            blk_in++;
        end
    endtask

    // Called at a falling edge: drive, observe, score the handshakes that the
    // coming rising edge will perform, then wait for the next falling edge.
    task automatic drive_cycle(input logic iv, input logic [DW-1:0] d, input logic ordy);
        exp_t e;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        cyc++;
        #1;
        in_acc = in_valid && in_ready;
        if (out_valid) n_valid_seen++;
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (in_ready && first_ready_cyc < 0) first_ready_cyc = cyc;
        if (stall_prev) begin
            check("valid held under stall", out_valid, 1);
            check("outputs held under stall", {out_data, out_index, out_last}, held);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious output", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_index", out_index, e.idx);
                check("out_last", out_last, e.last);
            end
            if (cap_n < DEPTH) begin
                cap_data[cap_n] = out_data;
                cap_idx[cap_n]  = out_index;
                cap_last[cap_n] = out_last;
                cap_n++;
            end
            n_out++;
            if (out_last) begin
                blk_out++;
                if (first_last_cyc < 0) first_last_cyc = cyc;
            end
        end
        stall_prev = out_valid && !out_ready;
        held = {out_data, out_index, out_last};
        if (in_acc) begin
            last_in_cyc = cyc;
            model_accept(in_data);
        end
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_index", out_index, 0);
        check("reset out_last", out_last, 0);
        check("reset bank_full", bank_full, 0);
        check("reset in_ready", in_ready, 0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("in_ready after reset", in_ready, 1);
        start_phase();
        @(negedge clock);
    endtask

    task automatic run_block(input logic [1:0] mode);
        int sent, budget;
        start_phase();
        rd_mode = mode;
        blk_mode[0] = mode;
        sent = 0;
        budget = 0;
        while (sent < DEPTH && budget < 500) begin
            drive_cycle(1'b1, DW'(sent), 1'b1);
            if (in_acc) sent++;
            budget++;
        end
        while (n_out < DEPTH && budget < 1000) begin
            drive_cycle(1'b0, '0, 1'b1);
            budget++;
        end
        check("block output count", n_out, DEPTH);
        check("first output latency", first_valid_cyc - last_in_cyc, 3);
        check("bank_full after drain", bank_full, 2'b00);
        check("out_valid after drain", out_valid, 0);
        for (int i = 0; i < DEPTH; i++) begin
            mode_data[mode][i] = cap_data[i];
            mode_idx[mode][i]  = cap_idx[i];
            mode_last[mode][i] = cap_last[i];
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, budget, total;
        int zz_first[10];

        vecs.push_back('{2'd0, 0, 8'd0, 1'b0});
        vecs.push_back('{2'd0, 1, 8'd1, 1'b0});
        vecs.push_back('{2'd0, 62, 8'd62, 1'b0});
        vecs.push_back('{2'd0, 63, 8'd63, 1'b1});
        vecs.push_back('{2'd1, 0, 8'd0, 1'b0});
        vecs.push_back('{2'd1, 1, 8'd8, 1'b0});
        vecs.push_back('{2'd1, 2, 8'd16, 1'b0});
        vecs.push_back('{2'd1, 7, 8'd56, 1'b0});
        vecs.push_back('{2'd1, 8, 8'd1, 1'b0});
        vecs.push_back('{2'd1, 9, 8'd9, 1'b0});
        vecs.push_back('{2'd1, 63, 8'd63, 1'b1});
        zz_first = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};
        for (int i = 0; i < 10; i++) vecs.push_back('{2'd2, i, DW'(zz_first[i]), 1'b0});
        vecs.push_back('{2'd2, 60, 8'd47, 1'b0});
        vecs.push_back('{2'd2, 61, 8'd55, 1'b0});
        vecs.push_back('{2'd2, 62, 8'd62, 1'b0});
        vecs.push_back('{2'd2, 63, 8'd63, 1'b1});

        init_orders();
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; rd_mode = 2'd0; out_ready = 1'b0;
        #2;
        check("initial out_valid", out_valid, 0);
        check("initial out_data", out_data, 0);
        check("initial out_index", out_index, 0);
        check("initial out_last", out_last, 0);
        check("initial bank_full", bank_full, 0);
        check("initial in_ready", in_ready, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        start_phase();

        // Directed blocks of 0..63 in each order, then the vector table.
        run_block(2'd0);
        run_block(2'd2);
        run_block(2'd1);
        for (int v = 0; v < vecs.size(); v++) begin
            int m, p;
            m = int'(vecs[v].mode);
            p = vecs[v].pos;
            check($sformatf("vector %0d data", v), mode_data[m][p], vecs[v].data);
            check($sformatf("vector %0d index", v), mode_idx[m][p], AW'(vecs[v].data));
            check($sformatf("vector %0d last", v), mode_last[m][p], vecs[v].last);
        end

        // Three blocks against a stalled output: third block must wait for a free bank.
        start_phase();
        rd_mode = 2'd0;
        for (int i = 0; i < 16; i++) blk_mode[i] = 2'd0;
        sent = 0;
        budget = 0;
        while (sent < 2 * DEPTH && budget < 500) begin
            drive_cycle(1'b1, DW'(sent), 1'b0);
            if (in_acc) sent++;
            budget++;
        end
        check("two banks accepted", sent, 2 * DEPTH);
        check("in_ready with both banks busy", in_ready, 0);
        check("bank_full with both banks busy", bank_full, 2'b11);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, DW'(sent), 1'b0);
            if (in_acc) sent++;
        end
        check("sample 129 held off", sent, 2 * DEPTH);
        first_ready_cyc = -1;
        while ((sent < 3 * DEPTH || n_out < 3 * DEPTH) && budget < 2000) begin
            drive_cycle(sent < 3 * DEPTH, DW'(sent), 1'b1);
            if (in_acc) sent++;
            budget++;
        end
        check("three blocks out", n_out, 3 * DEPTH);
        check("in_ready one cycle after out_last", first_ready_cyc, first_last_cyc + 1);
        check("bank_full after three blocks", bank_full, 2'b00);

        // Random traffic, random stalls, rd_mode scrambled while a block drains.
        start_phase();
        for (int i = 0; i < 16; i++) blk_mode[i] = 2'($urandom_range(0, 3));
        total = 6 * DEPTH;
        sent = 0;
        budget = 0;
        while ((sent < total || n_out < total) && budget < 6000) begin
            if (!out_valid)    rd_mode = blk_mode[blk_out % 16];
            else if (out_last) rd_mode = blk_mode[(blk_out + 1) % 16];
            else               rd_mode = 2'($urandom_range(0, 3));
            drive_cycle((sent < total) && ($urandom_range(0, 99) < 70), DW'($urandom),
                        1'($urandom_range(0, 1)));
            if (in_acc) sent++;
            budget++;
        end
        check("random output count", n_out, total);
        check("random block count", blk_out, 6);

        // Reset part-way through filling, then part-way through draining.
        start_phase();
        rd_mode = 2'd0;
        for (int i = 0; i < 16; i++) blk_mode[i] = 2'd0;
        sent = 0;
        budget = 0;
        while (sent < 40 && budget < 200) begin
            drive_cycle(1'b1, DW'(sent + 100), 1'b1);
            if (in_acc) sent++;
            budget++;
        end
        pulse_reset();
        sent = 0;
        while (sent < DEPTH - 1 && budget < 400) begin
            drive_cycle(1'b1, DW'($urandom), 1'b1);
            if (in_acc) sent++;
            budget++;
        end
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, '0, 1'b1);
        check("no output before a full block", n_valid_seen, 0);
        while (n_out < 20 && budget < 800) begin
            drive_cycle(1'b1, DW'($urandom), 1'b1);
            budget++;
        end
        check("reached output sample 20", n_out, 20);
        pulse_reset();
        sent = 0;
        budget = 0;
        while ((sent < DEPTH || n_out < DEPTH) && budget < 600) begin
            drive_cycle(sent < DEPTH, DW'($urandom), 1'b1);
            if (in_acc) sent++;
            budget++;
        end
        check("post-reset block count", n_out, DEPTH);
        check("post-reset bank_full", bank_full, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
